reaction_timer_param: RTL and testbench

//   Parametrised reaction-time benchmark, generation 2. On start it waits a pseudo-random delay,

---
 rtl/reaction_timer_param.sv | 230 +++++++++++++++++++++++
 tb/tb_reaction_timer_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_param.sv
// Reaction-time benchmark: random pre-delay, BCD ms count until user reacts, false-start and best-time tracking.
// Latency: state outputs follow the state register; digit/digit_sel are registered one cycle after source/select change.
// Backpressure: none; triggers are level inputs sampled every clk, scan outputs free-run for the downstream 7-seg driver.
module reaction_timer_param #(
    parameter int          CLK_PER_MS       = 50,
    parameter int          DIGITS           = 4,
    parameter int          DELAY_MIN_MS     = 1000,
    parameter int          DELAY_RANGE_LOG2 = 12,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter int          SCAN_DIV         = 1,
    localparam int         SEL_W            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_trigger,
    input  logic             user_trigger,
    input  logic             show_best,
    output logic             react,
    output logic             false_start,
    output logic             result_valid,
    output logic             overflow,
    output logic             best_valid,
    output logic [3:0]       digit,
    output logic [SEL_W-1:0] digit_sel
);

    localparam int          PRE_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int          DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [31:0] DLY_MASK = (32'd1 << DELAY_RANGE_LOG2) - 32'd1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REACT, S_SHOW, S_FALSE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_lfsr;
    logic [PRE_W-1:0]        r_pre;
    logic [31:0]             r_ms_left;
    logic [DIGITS-1:0][3:0]  r_result;
    logic [DIGITS-1:0][3:0]  r_best;
    logic                    r_ovf;
    logic                    r_best_vld;
    logic [DIV_W-1:0]        r_div;
    logic [SEL_W-1:0]        r_sel;
    logic [3:0]              r_digit;

    logic                    w_tick;
    logic                    w_enter_wait;
    logic                    w_enter_react;
    logic                    w_ms_dec;
    logic                    w_do_inc;
    logic                    w_set_ovf;
    logic                    w_to_show;
    logic [31:0]             w_delay;
    logic [DIGITS-1:0][3:0]  w_inc;
    logic                    w_carry;
    logic                    w_lt;
    logic                    w_decided;
    logic [DIGITS-1:0][3:0]  w_src;
    logic                    w_scan_adv;
    logic [SEL_W-1:0]        w_sel_nxt;
    logic [3:0]              w_digit_nxt;

    assign w_tick  = (r_pre == PRE_W'(CLK_PER_MS - 1));
    assign w_delay = 32'(DELAY_MIN_MS) + (DLY_MASK & {16'd0, r_lfsr});

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode, datapath strobes and status outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_enter_wait  = 1'b0;
        w_enter_react = 1'b0;
        w_ms_dec      = 1'b0;
        w_do_inc      = 1'b0;
        w_set_ovf     = 1'b0;
        w_to_show     = 1'b0;
        react         = 1'b0;
        false_start   = 1'b0;
        result_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_trigger) begin
                    w_state_nxt  = S_WAIT;
                    w_enter_wait = 1'b1;
                end
            end
            S_WAIT: begin
                // A user press beats delay expiry landing on the same cycle
                if (user_trigger) begin
                    w_state_nxt = S_FALSE;
                end else if (w_tick) begin
                    if (r_ms_left == 32'd1) begin
                        w_state_nxt   = S_REACT;
                        w_enter_react = 1'b1;
                    end else begin
                        w_ms_dec = 1'b1;
                    end
                end
            end
            S_REACT: begin
                react = 1'b1;
                // The press freezes the count; a tick on the same cycle is dropped
                if (user_trigger) begin
                    w_state_nxt = S_SHOW;
                    w_to_show   = 1'b1;
                end else if (w_tick) begin
                    if (w_carry) w_set_ovf = 1'b1;
                    else         w_do_inc  = 1'b1;
                end
            end
            S_SHOW: begin
                result_valid = 1'b1;
                if (start_trigger) begin
                    w_state_nxt  = S_WAIT;
                    w_enter_wait = 1'b1;
                end
            end
            S_FALSE: begin
                false_start = 1'b1;
                if (start_trigger) begin
                    w_state_nxt  = S_WAIT;
                    w_enter_wait = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Galois LFSR, taps 16/14/13/11, free-running outside reset
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // ms prescaler, realigned on WAIT and REACT entry so the first tick is a full ms later
    always_ff @(posedge clk) begin
        if (rst || w_enter_wait || w_enter_react || w_tick) r_pre <= '0;
        else                                                r_pre <= r_pre + 1'b1;
    end

    // BCD ripple increment; a final carry means every digit is already 9
    always_comb begin
        w_inc   = r_result;
        w_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_result[i] == 4'd9) begin
                    w_inc[i] = 4'd0;
                end else begin
                    w_inc[i] = r_result[i] + 4'd1;
                    w_carry  = 1'b0;
                end
            end
        end
    end

    // BCD magnitude compare, most-significant digit decides first
    always_comb begin
        w_lt      = 1'b0;
        w_decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!w_decided && (r_result[i] != r_best[i])) begin
                w_lt      = (r_result[i] < r_best[i]);
                w_decided = 1'b1;
            end
        end
    end

    // Delay countdown, result counter, overflow flag and best-time record
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms_left  <= '0;
            r_result   <= '0;
            r_best     <= '0;
            r_ovf      <= 1'b0;
            r_best_vld <= 1'b0;
        end else begin
            if (w_enter_wait) begin
                r_ms_left <= w_delay;
                r_result  <= '0;
                r_ovf     <= 1'b0;
            end
            if (w_ms_dec)  r_ms_left <= r_ms_left - 32'd1;
            if (w_do_inc)  r_result  <= w_inc;
            if (w_set_ovf) r_ovf     <= 1'b1;
            // Best updates on the REACT->SHOW edge with the frozen result; saturated runs never count
            if (w_to_show && !r_ovf && (!r_best_vld || w_lt)) begin
                r_best     <= r_result;
                r_best_vld <= 1'b1;
            end
        end
    end

    // Scan select and digit mux computed from the same next index so they stay aligned
    always_comb begin
        w_src       = show_best ? r_best : r_result;
        w_scan_adv  = (r_div == DIV_W'(SCAN_DIV - 1));
        w_sel_nxt   = r_sel;
        if (w_scan_adv) begin
            w_sel_nxt = (r_sel == SEL_W'(DIGITS - 1)) ? '0 : r_sel + 1'b1;
        end
        w_digit_nxt = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (SEL_W'(i) == w_sel_nxt) w_digit_nxt = w_src[i];
        end
    end

    // Scan registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_sel   <= '0;
            r_digit <= 4'd0;
        end else begin
            r_div   <= w_scan_adv ? '0 : r_div + 1'b1;
            r_sel   <= w_sel_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    assign overflow   = r_ovf;
    assign best_valid = r_best_vld;
    assign digit      = r_digit;
    assign digit_sel  = r_sel;

endmodule

// File: tb/tb_reaction_timer_param.sv
// Directed bench for reaction_timer_param: table of reaction runs plus hand sequences for corner cases.
// Inputs change and outputs are sampled on the falling clock edge.
// A second instance with a 4-bit random delay range is checked against an LFSR model.
module tb_reaction_timer_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_trigger = 1'b0;
    logic       user_trigger  = 1'b0;
    logic       show_best     = 1'b0;
    logic       react, false_start, result_valid, overflow, best_valid;
    logic [3:0] digit;
    logic [1:0] digit_sel;

    logic       start2 = 1'b0;
    logic       user2  = 1'b0;
    logic       react2, false2, rv2, ovf2, bv2;
    logic [3:0] digit2;
    logic [1:0] sel2;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    reaction_timer_param #(
        .CLK_PER_MS(4), .DIGITS(3), .DELAY_MIN_MS(2), .DELAY_RANGE_LOG2(0), .SCAN_DIV(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start_trigger(start_trigger), .user_trigger(user_trigger),
        .show_best(show_best), .react(react), .false_start(false_start),
        .result_valid(result_valid), .overflow(overflow), .best_valid(best_valid),
        .digit(digit), .digit_sel(digit_sel)
    );

    reaction_timer_param #(
        .CLK_PER_MS(4), .DIGITS(3), .DELAY_MIN_MS(2), .DELAY_RANGE_LOG2(4), .SCAN_DIV(1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start_trigger(start2), .user_trigger(user2),
        .show_best(1'b0), .react(react2), .false_start(false2),
        .result_valid(rv2), .overflow(ovf2), .best_valid(bv2),
        .digit(digit2), .digit_sel(sel2)
    );

    // Reference LFSR: Galois form of x^16+x^14+x^13+x^11+1, seeded on reset
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct {
        int          react_cyc;
        logic [11:0] exp_res;
        logic [11:0] exp_best;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle start pulse; returns at the falling edge of the first WAIT cycle
    task automatic start_run();
        start_trigger = 1'b1;
        cyc(1);
        start_trigger = 1'b0;
    endtask

    // Counts falling edges until react is seen, bounded
    task automatic wait_react(output int lat);
        lat = 0;
        while (!react && lat < 200) begin
            cyc(1);
            lat++;
        end
    endtask

    // Holds user_trigger for the n-th REACT cycle (counting from 0)
    task automatic react_after(input int n);
        cyc(n);
        user_trigger = 1'b1;
        cyc(1);
        user_trigger = 1'b0;
    endtask

    // Collects one full scan round of the chosen source
    task automatic read_disp(input logic sb, output logic [11:0] v);
        int s;
        v = '0;
        show_best = sb;
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            s = int'(digit_sel);
            if (s < 3) v[s*4 +: 4] = digit;
            cyc(1);
        end
        show_best = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          seen;
        int          prev_sel;
        int          s;
        int          exp_ms;
        logic [11:0] v;
        logic [11:0] ref123;
        logic [11:0] ref_best;

        vecs[0] = '{react_cyc: 14, exp_res: 12'h003, exp_best: 12'h003};
        vecs[1] = '{react_cyc: 40, exp_res: 12'h010, exp_best: 12'h003};
        vecs[2] = '{react_cyc: 8,  exp_res: 12'h002, exp_best: 12'h002};

        // Reset state
        cyc(3);
        chk("rst_react", react, 0);
        chk("rst_false", false_start, 0);
        chk("rst_rvalid", result_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_bvalid", best_valid, 0);
        chk("rst_digit", digit, 0);
        chk("rst_sel", digit_sel, 0);
        rst = 1'b0;
        cyc(2);

        // Table-driven reaction runs
        for (int i = 0; i < 3; i++) begin
            start_run();
            wait_react(lat);
            chk("react_lat", lat, 8);
            react_after(vecs[i].react_cyc);
            chk("show_rvalid", result_valid, 1);
            chk("show_react", react, 0);
            chk("show_ovf", overflow, 0);
            chk("show_bvalid", best_valid, 1);
            read_disp(1'b0, v);
            chk("run_result", v, vecs[i].exp_res);
            read_disp(1'b1, v);
            chk("run_best", v, vecs[i].exp_best);
        end

        // False start at WAIT cycle 5
        start_run();
        cyc(5);
        user_trigger = 1'b1;
        cyc(1);
        user_trigger = 1'b0;
        chk("fs_flag", false_start, 1);
        chk("fs_react", react, 0);
        chk("fs_rvalid", result_valid, 0);
        seen = 0;
        repeat (20) begin
            if (react) seen = 1;
            cyc(1);
        end
        chk("fs_react_never", seen, 0);
        chk("fs_flag_held", false_start, 1);
        read_disp(1'b0, v);
        chk("fs_result", v, 12'h000);
        read_disp(1'b1, v);
        chk("fs_best", v, 12'h002);

        // Restart from FALSE, then never react: saturation
        start_run();
        chk("fs_cleared", false_start, 0);
        wait_react(lat);
        chk("ovf_react_lat", lat, 8);
        cyc(4100);
        chk("ovf_react", react, 1);
        chk("ovf_flag", overflow, 1);
        read_disp(1'b0, v);
        chk("ovf_result", v, 12'h999);
        chk("ovf_still_react", react, 1);
        react_after(0);
        chk("ovf_show", result_valid, 1);
        chk("ovf_flag_show", overflow, 1);
        read_disp(1'b1, v);
        chk("ovf_best", v, 12'h002);

        // Result 123 for the scan checks; overflow clears on the new run
        start_run();
        chk("ovf_clear", overflow, 0);
        wait_react(lat);
        chk("scan_react_lat", lat, 8);
        react_after(492);
        chk("scan_show", result_valid, 1);
        ref123   = 12'h123;
        ref_best = 12'h002;
        show_best = 1'b0;
        cyc(1);
        prev_sel = int'(digit_sel);
        for (int k = 0; k < 4; k++) begin
            s = int'(digit_sel);
            if (k > 0) chk("scan_sel_step", s, (prev_sel + 1) % 3);
            if (s < 3) chk("scan_dig_res", digit, ref123[s*4 +: 4]);
            else       chk("scan_sel_range", s, 0);
            prev_sel = s;
            cyc(1);
        end
        show_best = 1'b1;
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            s = int'(digit_sel);
            if (s < 3) chk("scan_dig_best", digit, ref_best[s*4 +: 4]);
            else       chk("scan_sel_range", s, 0);
            cyc(1);
        end
        show_best = 1'b0;

        // Reset pulse in the middle of REACT
        start_run();
        wait_react(lat);
        cyc(10);
        chk("mid_react", react, 1);
        rst = 1'b1;
        cyc(1);
        chk("mr_react", react, 0);
        chk("mr_false", false_start, 0);
        chk("mr_rvalid", result_valid, 0);
        chk("mr_ovf", overflow, 0);
        chk("mr_bvalid", best_valid, 0);
        chk("mr_digit", digit, 0);
        chk("mr_sel", digit_sel, 0);
        rst = 1'b0;
        cyc(20);
        chk("mr_idle", react, 0);
        read_disp(1'b0, v);
        chk("mr_result", v, 12'h000);

        // Random delay range on the second instance: 2..17 ms, matching the LFSR draw
        for (int r = 0; r < 50; r++) begin
            cyc($urandom_range(0, 3));
            exp_ms = 2 + int'(m_lfsr & 16'h000F);
            start2 = 1'b1;
            cyc(1);
            start2 = 1'b0;
            lat = 0;
            while (!react2 && lat < 100) begin
                cyc(1);
                lat++;
            end
            chk("rnd_delay", lat, exp_ms * 4);
            chk("rnd_range", (lat >= 8 && lat <= 68), 1);
            user2 = 1'b1;
            cyc(1);
            user2 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
